// File: rtl/i2c_master_write_sequencer.sv
// Byte-level I2C write sequencer: START, 8 data bits MSB first, ACK slot, optional STOP, driven over the go/command/finish handshake.
// Latency: one ISSUE cycle plus the bit unit's run time per bit, plus one DONE cycle; tx_ready returns the cycle after done.
// Backpressure: tx_ready is high only in IDLE. A request held on tx_valid while busy waits until the current byte completes.
module i2c_master_write_sequencer #(
  parameter bit          ABORT_ON_NACK  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       tx_stop,
  output logic       bit_go,
  output logic [2:0] bit_command,
  input  logic       bit_finish,
  input  logic       sda_in,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       timeout_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_START = 3'b010;
  localparam logic [2:0] CMD_STOP  = 3'b011;
  localparam logic [2:0] CMD_NACK  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t          state;
  logic [7:0]      data_q;
  logic            stop_q;
  logic [2:0]      bit_idx;
  logic [TW-1:0]   tcnt;

  // Sequencer FSM. Within each bit state, bit_go=0 marks the ISSUE cycle and
  // bit_go=1 marks RUN; the command for the next bit is loaded on the same edge
  // that drops bit_go, so every bit starts with exactly one low cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      data_q        <= 8'h00;
      stop_q        <= 1'b0;
      bit_idx       <= 3'd0;
      tcnt          <= '0;
      tx_ready      <= 1'b1;
      bit_go        <= 1'b0;
      bit_command   <= CMD_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      ack_error     <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid && tx_ready) begin
            data_q        <= tx_data;
            stop_q        <= tx_stop;
            ack_error     <= 1'b0;
            timeout_error <= 1'b0;
            tx_ready      <= 1'b0;
            busy          <= 1'b1;
            bit_go        <= 1'b0;
            bit_idx       <= 3'd7;
            tcnt          <= '0;
            if (tx_start) begin
              state       <= S_START;
              bit_command <= CMD_START;
            end else begin
              state       <= S_DATA;
              bit_command <= {2'b10, tx_data[7]};
            end
          end
        end

        S_START, S_DATA, S_ACK, S_STOP: begin
          if (!bit_go) begin
            // ISSUE: command already stable, start the bit and clear the watchdog
            bit_go <= 1'b1;
            tcnt   <= '0;
          end else if (bit_finish) begin
            bit_go <= 1'b0;
            tcnt   <= '0;
            case (state)
              S_START: begin
                state       <= S_DATA;
                bit_idx     <= 3'd7;
                bit_command <= {2'b10, data_q[7]};
              end
              S_DATA: begin
                if (bit_idx == 3'd0) begin
                  state       <= S_ACK;
                  bit_command <= CMD_NACK;
                end else begin
                  bit_idx     <= bit_idx - 3'd1;
                  bit_command <= {2'b10, data_q[bit_idx - 3'd1]};
                end
              end
              S_ACK: begin
                // SDA high in the ACK slot means the slave did not acknowledge
                ack_error <= sda_in;
                if (stop_q || (sda_in && ABORT_ON_NACK)) begin
                  state       <= S_STOP;
                  bit_command <= CMD_STOP;
                end else begin
                  state       <= S_DONE;
                  bit_command <= CMD_IDLE;
                  done        <= 1'b1;
                end
              end
              default: begin
                state       <= S_DONE;
                bit_command <= CMD_IDLE;
                done        <= 1'b1;
              end
            endcase
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Bit unit stalled: abandon the byte without a STOP
            bit_go        <= 1'b0;
            state         <= S_DONE;
            bit_command   <= CMD_IDLE;
            done          <= 1'b1;
            timeout_error <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end

        default: begin
          state       <= S_IDLE;
          tx_ready    <= 1'b1;
          busy        <= 1'b0;
          bit_go      <= 1'b0;
          bit_command <= CMD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_write_sequencer.sv
// Bench for the I2C write sequencer: random bytes against a command-list reference model.
// A behavioural bit unit answers each bit after a random delay and drives SDA in the ACK slot.
// Directed cases cover timeout, reset mid-byte and a request held across two bytes.
module tb_i2c_master_write_sequencer;

  localparam bit ABORT = 1'b1;

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_stop;
  logic       bit_go;
  logic [2:0] bit_command;
  logic       bit_finish;
  logic       sda_in;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic       timeout_error;

  i2c_master_write_sequencer #(.ABORT_ON_NACK(ABORT), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset(reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_stop(tx_stop),
    .bit_go(bit_go), .bit_command(bit_command), .bit_finish(bit_finish),
    .sda_in(sda_in), .busy(busy), .done(done),
    .ack_error(ack_error), .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural bit unit and done monitor ----------------
  bit         hang = 1'b0;
  logic       ack_val = 1'b0;
  logic [2:0] cmd_q[$];
  logic [2:0] exp_q[$];
  int         done_cnt = 0;
  logic       done_ack = 1'b0;
  logic       done_to = 1'b0;
  int         last_run = 0;

  initial begin
    logic       prev_go, prev_done, fin_last;
    logic [2:0] cur_cmd;
    int         rem, run_len;
    prev_go = 0; prev_done = 0; fin_last = 0; cur_cmd = 0; rem = 0; run_len = 0;
    bit_finish = 1'b0;
    sda_in = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (done) begin
        chk_eq("done_one_cycle", prev_done, 1'b0);
        done_cnt++;
        done_ack = ack_error;
        done_to  = timeout_error;
      end
      prev_done = done;
      if (fin_last) chk_eq("go_falls_after_finish", bit_go, 1'b0);
      fin_last   = 1'b0;
      bit_finish = 1'b0;
      if (bit_go && !prev_go) begin
        cur_cmd = bit_command;
        cmd_q.push_back(bit_command);
        rem     = $urandom_range(1, 7);
        run_len = 1;
        sda_in  = (bit_command == 3'b111) ? ack_val : 1'($urandom);
      end else if (bit_go) begin
        chk_eq("cmd_stable", bit_command, cur_cmd);
        run_len++;
      end else if (prev_go) begin
        last_run = run_len;
      end
      if (bit_go && !hang) begin
        rem--;
        if (rem == 0) begin
          bit_finish = 1'b1;
          fin_last   = 1'b1;
        end
      end
      prev_go = bit_go;
    end
  end

  // ---------------- reference model: command list for one byte ----------------
  task automatic build_exp(input logic s, input logic [7:0] d, input logic p, input logic a);
    if (s) exp_q.push_back(3'b010);
    for (int i = 7; i >= 0; i--) exp_q.push_back({2'b10, d[i]});
    exp_q.push_back(3'b111);
    if (p || (a && ABORT)) exp_q.push_back(3'b011);
  endtask

  task automatic compare_cmds();
    chk_eq("cmd_count", cmd_q.size(), exp_q.size());
    for (int i = 0; i < cmd_q.size() && i < exp_q.size(); i++)
      chk_eq($sformatf("cmd[%0d]", i), cmd_q[i], exp_q[i]);
    cmd_q.delete();
    exp_q.delete();
  endtask

  task automatic offer(input logic s, input logic [7:0] d, input logic p);
    for (int k = 0; k < 200 && !tx_ready; k++) @(negedge clock);
    chk_eq("ready_before_offer", tx_ready, 1'b1);
    tx_valid = 1'b1; tx_start = s; tx_data = d; tx_stop = p;
    @(negedge clock);
    chk_eq("ready_drops", tx_ready, 1'b0);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 3000 && done_cnt < target; k++) @(negedge clock);
    chk_eq("done_seen", (done_cnt >= target), 1'b1);
  endtask

  task automatic run_byte(input logic s, input logic [7:0] d, input logic p, input logic a);
    int n0;
    ack_val = a;
    cmd_q.delete();
    exp_q.delete();
    build_exp(s, d, p, a);
    n0 = done_cnt;
    offer(s, d, p);
    wait_done(n0 + 1);
    compare_cmds();
    chk_eq("ack_error_at_done", done_ack, a);
    chk_eq("timeout_at_done", done_to, 1'b0);
    @(negedge clock);
    chk_eq("ready_after_done", tx_ready, 1'b1);
    chk_eq("done_low_after", done, 1'b0);
    chk_eq("busy_low_after", busy, 1'b0);
    chk_eq("ack_error_held", ack_error, a);
    chk_eq("done_count", done_cnt, n0 + 1);
  endtask

  initial begin
    logic [7:0] d;
    int n0;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_start = 1'b0; tx_stop = 1'b0;
    repeat (2) @(negedge clock);
    chk_eq("rst_tx_ready", tx_ready, 1'b1);
    chk_eq("rst_bit_go", bit_go, 1'b0);
    chk_eq("rst_bit_command", bit_command, 3'b000);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_done", done, 1'b0);
    chk_eq("rst_ack_error", ack_error, 1'b0);
    chk_eq("rst_timeout_error", timeout_error, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Directed bytes
    run_byte(1'b1, 8'hA5, 1'b1, 1'b0);
    run_byte(1'b0, 8'h00, 1'b0, 1'b0);
    run_byte(1'b0, 8'hFF, 1'b0, 1'b1);

    // Randomized bytes
    for (int t = 0; t < 20; t++)
      run_byte(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    // Timeout: bit unit never finishes
    hang = 1'b1;
    ack_val = 1'b0;
    cmd_q.delete();
    exp_q.delete();
    exp_q.push_back(3'b010);
    n0 = done_cnt;
    offer(1'b1, 8'($urandom), 1'b1);
    wait_done(n0 + 1);
    compare_cmds();
    chk_eq("timeout_run_len", last_run, 64);
    chk_eq("timeout_flag", done_to, 1'b1);
    chk_eq("timeout_ack_flag", done_ack, 1'b0);
    hang = 1'b0;
    @(negedge clock);
    chk_eq("timeout_ready_after", tx_ready, 1'b1);

    // Clean byte afterwards clears the error flags
    run_byte(1'b1, 8'h3C, 1'b1, 1'b0);

    // Reset during data bit 3
    d = 8'($urandom);
    ack_val = 1'b0;
    cmd_q.delete();
    offer(1'b0, d, 1'b1);
    for (int k = 0; k < 500 && !(cmd_q.size() == 5 && bit_go); k++) @(negedge clock);
    chk_eq("reached_bit3", (cmd_q.size() == 5 && bit_go), 1'b1);
    if (cmd_q.size() == 5) chk_eq("bit3_cmd", cmd_q[4], {2'b10, d[3]});
    n0 = done_cnt;
    reset = 1'b1;
    @(negedge clock);
    chk_eq("midrst_bit_go", bit_go, 1'b0);
    chk_eq("midrst_busy", busy, 1'b0);
    chk_eq("midrst_tx_ready", tx_ready, 1'b1);
    chk_eq("midrst_bit_command", bit_command, 3'b000);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk_eq("midrst_no_done", done_cnt, n0);
    cmd_q.delete();

    // tx_valid held across two bytes
    ack_val = 1'b0;
    exp_q.delete();
    build_exp(1'b1, 8'h5A, 1'b0, 1'b0);
    build_exp(1'b0, 8'hC3, 1'b1, 1'b0);
    n0 = done_cnt;
    tx_valid = 1'b1; tx_start = 1'b1; tx_data = 8'h5A; tx_stop = 1'b0;
    @(negedge clock);
    chk_eq("held_ready_drops", tx_ready, 1'b0);
    tx_start = 1'b0; tx_data = 8'hC3; tx_stop = 1'b1;
    for (int k = 0; k < 3000 && !tx_ready; k++) @(negedge clock);
    chk_eq("held_ready_back", tx_ready, 1'b1);
    chk_eq("held_second_after_done", done_cnt, n0 + 1);
    chk_eq("held_not_busy", busy, 1'b0);
    @(negedge clock);
    tx_valid = 1'b0;
    chk_eq("held_second_accepted", tx_ready, 1'b0);
    wait_done(n0 + 2);
    compare_cmds();
    chk_eq("held_ack", done_ack, 1'b0);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
